// File: rtl/alu_operand_sequencer_pkg.sv
// alu_seq_pkg: sequencer state encoding, ALU opcodes and opcode legality check
package alu_seq_pkg;
    typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, SHOW} state_t;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_MUL = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    function automatic logic op_supported(input logic [2:0] op);
        return op inside {OP_ADD, OP_MUL, OP_AND, OP_SUB, OP_OR};
    endfunction
endpackage

// File: rtl/alu_operand_sequencer_rise.sv
// rise_detect: one-cycle pulse on a rising level; a level already high out of reset must drop first
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic level_i,
    output logic pulse_o
);
    logic level_q, armed_q;
    // level history plus an arm flag that sets once the level has been seen low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            level_q <= level_i;
            armed_q <= armed_q | ~level_i;
        end
    end
    assign pulse_o = level_i & ~level_q & armed_q;
endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: serial A/B/opcode collection for the ALU with result capture and chaining
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enter,
    input  logic             clear,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] result_out,
    output logic             result_vld,
    output logic             op_err,
    output logic [1:0]       phase
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]       op_q, op_d;
    logic             vld_q, vld_d, err_q, err_d, enter_p;

    rise_detect u_enter (
        .clk     (clk),
        .reset_n (reset_n),
        .level_i (enter),
        .pulse_o (enter_p)
    );

    // state and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    // next state and register loads; clear overrides any press
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        vld_d   = vld_q;
        err_d   = err_q;
        if (clear) begin
            state_d = WAIT_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            res_d   = '0;
            vld_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                WAIT_A: if (enter_p) begin
                    a_d     = data_in;
                    vld_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = WAIT_B;
                end
                WAIT_B: if (enter_p) begin
                    b_d     = data_in;
                    state_d = WAIT_OP;
                end
                WAIT_OP: if (enter_p) begin
                    op_d    = data_in[2:0];
                    state_d = EXEC;
                end
                EXEC: begin
                    res_d   = alu_result;
                    vld_d   = 1'b1;
                    err_d   = !op_supported(op_q);
                    state_d = SHOW;
                end
                SHOW: if (enter_p) begin
                    a_d     = res_q;
                    vld_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = WAIT_B;
                end
                default: state_d = WAIT_A;
            endcase
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign result_out = res_q;
    assign result_vld = vld_q;
    assign op_err     = err_q;
    assign phase      = (state_q == WAIT_B) ? 2'd1 :
                        (state_q == WAIT_OP || state_q == EXEC) ? 2'd2 :
                        (state_q == SHOW) ? 2'd3 : 2'd0;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: directed checks of the operand sequencer against a behavioural ALU
module tb_alu_operand_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] data_in = '0;
    logic        enter = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] alu_a, alu_b, alu_result, result_out;
    logic [2:0]  alu_op;
    logic        result_vld, op_err;
    logic [1:0]  phase;
    int          errors = 0;
    int          checks = 0;

    alu_operand_sequencer #(.WIDTH(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .enter      (enter),
        .clear      (clear),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .result_out (result_out),
        .result_vld (result_vld),
        .op_err     (op_err),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    // stand-in for the combinational ALU: truncating arithmetic, 0 for unsupported opcodes
    always_comb begin
        alu_result = '0;
        case (alu_op)
            3'd0: alu_result = alu_a + alu_b;
            3'd1: alu_result = alu_a * alu_b;
            3'd2: alu_result = alu_a & alu_b;
            3'd4: alu_result = alu_a - alu_b;
            3'd5: alu_result = alu_a | alu_b;
            default: alu_result = '0;
        endcase
    end

    task automatic press(input logic [15:0] v);
        @(negedge clk);
        data_in = v;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        enter = 1'b1;
        data_in = 16'd77;
        repeat (3) @(negedge clk);
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase got=%0d exp=0", phase); end
        checks++; if ({alu_a, alu_b, alu_op, result_out} !== 51'd0) begin errors++; $display("FAIL reset_regs a=%0d b=%0d op=%0d r=%0d exp=0", alu_a, alu_b, alu_op, result_out); end
        checks++; if ({result_vld, op_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {result_vld, op_err}); end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL held_release_phase got=%0d exp=0", phase); end
        checks++; if (alu_a !== 16'd0) begin errors++; $display("FAIL held_release_a got=%0d exp=0", alu_a); end
        enter = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        press(16'd7);
        checks++; if (phase !== 2'd1 || alu_a !== 16'd7) begin errors++; $display("FAIL basic_a phase=%0d a=%0d exp 1/7", phase, alu_a); end
        press(16'd5);
        checks++; if (phase !== 2'd2 || alu_b !== 16'd5) begin errors++; $display("FAIL basic_b phase=%0d b=%0d exp 2/5", phase, alu_b); end
        press(16'd0);
        @(negedge clk);
        checks++; if (result_out !== 16'd12) begin errors++; $display("FAIL basic_result got=%0d exp=12", result_out); end
        checks++; if (result_vld !== 1'b1 || op_err !== 1'b0) begin errors++; $display("FAIL basic_flags vld=%b err=%b exp 1/0", result_vld, op_err); end
        checks++; if (phase !== 2'd3) begin errors++; $display("FAIL basic_phase got=%0d exp=3", phase); end
    endtask

    task automatic test_chain();
        press(16'd999);
        checks++; if (alu_a !== 16'd12 || phase !== 2'd1 || result_vld !== 1'b0) begin errors++; $display("FAIL chain_load a=%0d phase=%0d vld=%b exp 12/1/0", alu_a, phase, result_vld); end
        press(16'd3);
        press(16'd4);
        @(negedge clk);
        checks++; if (result_out !== 16'd9 || op_err !== 1'b0 || result_vld !== 1'b1) begin errors++; $display("FAIL chain_result r=%0d err=%b vld=%b exp 9/0/1", result_out, op_err, result_vld); end
        checks++; if (alu_op !== 3'd4 || alu_b !== 16'd3) begin errors++; $display("FAIL chain_ops op=%0d b=%0d exp 4/3", alu_op, alu_b); end
    endtask

    task automatic test_mul();
        do_clear();
        checks++; if (phase !== 2'd0 || result_vld !== 1'b0 || alu_a !== 16'd0) begin errors++; $display("FAIL clear_show phase=%0d vld=%b a=%0d exp 0/0/0", phase, result_vld, alu_a); end
        press(16'd300);
        press(16'd300);
        press(16'd1);
        checks++; if (result_vld !== 1'b0 || phase !== 2'd2) begin errors++; $display("FAIL mul_exec vld=%b phase=%0d exp 0/2", result_vld, phase); end
        @(negedge clk);
        checks++; if (result_out !== 16'd24464 || result_vld !== 1'b1) begin errors++; $display("FAIL mul_result r=%0d vld=%b exp 24464/1", result_out, result_vld); end
    endtask

    task automatic test_bad_op();
        do_clear();
        press(16'd1);
        press(16'd2);
        press(16'd6);
        @(negedge clk);
        checks++; if (result_out !== 16'd0 || op_err !== 1'b1 || result_vld !== 1'b1) begin errors++; $display("FAIL badop r=%0d err=%b vld=%b exp 0/1/1", result_out, op_err, result_vld); end
        repeat (3) @(negedge clk);
        checks++; if (op_err !== 1'b1 || phase !== 2'd3) begin errors++; $display("FAIL badop_hold err=%b phase=%0d exp 1/3", op_err, phase); end
        press(16'd50);
        checks++; if (op_err !== 1'b0 || alu_a !== 16'd0 || phase !== 2'd1) begin errors++; $display("FAIL badop_clear err=%b a=%0d phase=%0d exp 0/0/1", op_err, alu_a, phase); end
    endtask

    task automatic test_hold();
        do_clear();
        @(negedge clk);
        data_in = 16'd55;
        enter = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (alu_a !== 16'd55 || alu_b !== 16'd0 || phase !== 2'd1) begin errors++; $display("FAIL hold a=%0d b=%0d phase=%0d exp 55/0/1", alu_a, alu_b, phase); end
        enter = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clear_wins();
        press(16'd9);
        checks++; if (phase !== 2'd2 || alu_b !== 16'd9) begin errors++; $display("FAIL cw_setup phase=%0d b=%0d exp 2/9", phase, alu_b); end
        @(negedge clk);
        data_in = 16'd5;
        enter = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        clear = 1'b0;
        checks++; if (phase !== 2'd0 || {alu_a, alu_b, alu_op, result_out} !== 51'd0 || {result_vld, op_err} !== 2'b00) begin errors++; $display("FAIL clear_wins phase=%0d a=%0d b=%0d op=%0d r=%0d exp all 0", phase, alu_a, alu_b, alu_op, result_out); end
        repeat (2) @(negedge clk);
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL clear_stay phase=%0d exp=0", phase); end
    endtask

    task automatic test_reset_exec();
        press(16'd7);
        press(16'd5);
        press(16'd0);
        checks++; if (phase !== 2'd2) begin errors++; $display("FAIL rx_exec phase=%0d exp=2", phase); end
        reset_n = 1'b0;
        #1;
        checks++; if (phase !== 2'd0 || result_vld !== 1'b0 || alu_a !== 16'd0) begin errors++; $display("FAIL rx_async phase=%0d vld=%b a=%0d exp 0/0/0", phase, result_vld, alu_a); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (result_vld !== 1'b0 || result_out !== 16'd0 || phase !== 2'd0) begin errors++; $display("FAIL rx_after vld=%b r=%0d phase=%0d exp 0/0/0", result_vld, result_out, phase); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_chain();
        test_mul();
        test_bad_op();
        test_hold();
        test_clear_wins();
        test_reset_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
